// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// div_sequencer : RV32M DIV/DIVU/REM/REMU multi-cycle controller with a
//                 radix-2 restoring datapath and held quotient/remainder regs.
// Revision      : 1.0
// ============================================================================
module div_sequencer #(
   parameter int XLEN = 32,
   parameter int CNTW = 6
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            DivStartE,
   input  logic            DivSignedE,
   input  logic            RemSelE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            AbortE,
   output logic            DivStallE,
   output logic            DivValidE,
   output logic            DivBusyE,
   output logic [XLEN-1:0] DivResultE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] c_min_int  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNTW-1:0] c_last_cnt = CNTW'(XLEN-1);

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;
   logic [XLEN-1:0] p_q,     p_d;
   logic [XLEN-1:0] d_q,     d_d;
   logic [XLEN-1:0] b_q,     b_d;
   logic            negq_q,  negq_d;
   logic            negr_q,  negr_d;
   logic [XLEN-1:0] quo_q,   quo_d;
   logic [XLEN-1:0] rem_q,   rem_d;

   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   shifted, diff;
   logic            qbit;
   logic [XLEN-1:0] p_next, d_next;

   // Magnitudes of the incoming operands (only negated for signed ops)
   assign abs_a = (DivSignedE && SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
   assign abs_b = (DivSignedE && SrcBE[XLEN-1]) ? -SrcBE : SrcBE;

   // One restoring step: the XLEN+1-bit difference's MSB is its sign
   assign shifted = {p_q, d_q[XLEN-1]};
   assign diff    = shifted - {1'b0, b_q};
   assign qbit    = ~diff[XLEN];
   assign p_next  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign d_next  = {d_q[XLEN-2:0], qbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      d_d     = d_q;
      b_d     = b_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quo_d   = quo_q;
      rem_d   = rem_q;

      if (AbortE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (DivStartE) begin
                  b_d    = abs_b;
                  negq_d = DivSignedE & (SrcAE[XLEN-1] ^ SrcBE[XLEN-1]);
                  negr_d = DivSignedE & SrcAE[XLEN-1];
                  if (SrcBE == '0) begin
                     quo_d   = '1;
                     rem_d   = SrcAE;
                     state_d = DONE;
                  end else if (DivSignedE && SrcAE == c_min_int && SrcBE == '1) begin
                     quo_d   = c_min_int;
                     rem_d   = '0;
                     state_d = DONE;
                  end else begin
                     cnt_d   = '0;
                     p_d     = '0;
                     d_d     = abs_a;
                     state_d = BUSY;
                  end
               end
            end
            BUSY: begin
               p_d   = p_next;
               d_d   = d_next;
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == c_last_cnt) begin
                  quo_d   = negq_q ? -d_next : d_next;
                  rem_d   = negr_q ? -p_next : p_next;
                  state_d = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         d_q     <= '0;
         b_q     <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         d_q     <= d_d;
         b_q     <= b_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   // The start cycle itself is stalled so the instruction stays in E
   assign DivStallE  = ((state_q == IDLE) && DivStartE && !AbortE) || (state_q == BUSY);
   assign DivValidE  = (state_q == DONE);
   assign DivBusyE   = (state_q == BUSY);
   assign DivResultE = RemSelE ? rem_q : quo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// Self-checking bench for div_sequencer: directed RV32M cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_div_sequencer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        DivStartE, DivSignedE, RemSelE, AbortE;
   logic [31:0] SrcAE, SrcBE;
   logic        DivStallE, DivValidE, DivBusyE;
   logic [31:0] DivResultE;

   int n_pass  = 0;
   int n_total = 0;

   div_sequencer #(.XLEN(32), .CNTW(6)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DivStartE  (DivStartE),
      .DivSignedE (DivSignedE),
      .RemSelE    (RemSelE),
      .SrcAE      (SrcAE),
      .SrcBE      (SrcBE),
      .AbortE     (AbortE),
      .DivStallE  (DivStallE),
      .DivValidE  (DivValidE),
      .DivBusyE   (DivBusyE),
      .DivResultE (DivResultE)
   );

   always #5 CLK = ~CLK;

   // RISC-V division semantics from plain arithmetic
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn,
                                   output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issues one operation at cycle 0 (start held through DONE) and records
   // what happened; callers do the comparisons.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int vcyc, output int nstall, output int nvalid,
                        output int last_stall);
      @(posedge CLK); #1;
      DivStartE = 1'b1; SrcAE = a; SrcBE = b; DivSignedE = sgn;
      vcyc = -1; nstall = 0; nvalid = 0; last_stall = -1;
      for (int c = 0; c < 45; c++) begin
         @(negedge CLK);
         if (DivStallE) begin nstall++; last_stall = c; end
         if (DivValidE) begin nvalid++; if (vcyc < 0) vcyc = c; end
         @(posedge CLK); #1;
         if (vcyc >= 0 && c == vcyc) DivStartE = 1'b0;
         if (vcyc >= 0 && c >= vcyc + 3) break;
      end
      DivStartE = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; DivStartE = 1'b0; DivSignedE = 1'b0; RemSelE = 1'b0;
      AbortE = 1'b0; SrcAE = 32'd0; SrcBE = 32'd0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      n_total++; if (DivStallE !== 1'b0) $display("FAIL reset_stall got %b want 0", DivStallE); else n_pass++;
      n_total++; if (DivValidE !== 1'b0) $display("FAIL reset_valid got %b want 0", DivValidE); else n_pass++;
      n_total++; if (DivBusyE !== 1'b0) $display("FAIL reset_busy got %b want 0", DivBusyE); else n_pass++;
      n_total++; if (DivResultE !== 32'd0) $display("FAIL reset_quo got %h want 0", DivResultE); else n_pass++;
      RemSelE = 1'b1; #1;
      n_total++; if (DivResultE !== 32'd0) $display("FAIL reset_rem got %h want 0", DivResultE); else n_pass++;
      RemSelE = 1'b0;
   endtask

   task automatic test_divu;
      int vc, ns, nv, ls;
      RemSelE = 1'b0;
      do_op(32'd100, 32'd7, 1'b0, vc, ns, nv, ls);
      n_total++; if (vc !== 33) $display("FAIL divu_valid_cycle got %0d want 33", vc); else n_pass++;
      n_total++; if (ns !== 33) $display("FAIL divu_stall_cycles got %0d want 33", ns); else n_pass++;
      n_total++; if (ls !== 32) $display("FAIL divu_last_stall got %0d want 32", ls); else n_pass++;
      n_total++; if (DivResultE !== 32'd14) $display("FAIL divu_quo got %0d want 14", DivResultE); else n_pass++;
      RemSelE = 1'b1; #1;
      n_total++; if (DivResultE !== 32'd2) $display("FAIL divu_rem got %0d want 2", DivResultE); else n_pass++;
      RemSelE = 1'b0;
   endtask

   task automatic test_signed_cached;
      int vc, ns, nv, ls;
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, vc, ns, nv, ls);
      n_total++; if (vc !== 33) $display("FAIL div_neg_valid_cycle got %0d want 33", vc); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         RemSelE = 1'b0; #1;
         n_total++; if (DivResultE !== 32'hFFFF_FFFD) $display("FAIL cached_quo got %h want fffffffd", DivResultE); else n_pass++;
         n_total++; if (DivStallE !== 1'b0) $display("FAIL cached_stall got %b want 0", DivStallE); else n_pass++;
         RemSelE = 1'b1; #1;
         n_total++; if (DivResultE !== 32'hFFFF_FFFF) $display("FAIL cached_rem got %h want ffffffff", DivResultE); else n_pass++;
         @(posedge CLK); #1;
      end
      RemSelE = 1'b0;
   endtask

   task automatic test_special;
      int vc, ns, nv, ls;
      do_op(32'd5, 32'd0, 1'b1, vc, ns, nv, ls);
      n_total++; if (vc !== 1) $display("FAIL div0_valid_cycle got %0d want 1", vc); else n_pass++;
      n_total++; if (ns !== 1 || ls !== 0) $display("FAIL div0_stall got %0d/%0d want 1/0", ns, ls); else n_pass++;
      RemSelE = 1'b0; #1;
      n_total++; if (DivResultE !== 32'hFFFF_FFFF) $display("FAIL div0_quo got %h want ffffffff", DivResultE); else n_pass++;
      RemSelE = 1'b1; #1;
      n_total++; if (DivResultE !== 32'd5) $display("FAIL div0_rem got %h want 5", DivResultE); else n_pass++;
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, vc, ns, nv, ls);
      n_total++; if (vc !== 1) $display("FAIL ovf_valid_cycle got %0d want 1", vc); else n_pass++;
      RemSelE = 1'b0; #1;
      n_total++; if (DivResultE !== 32'h8000_0000) $display("FAIL ovf_quo got %h want 80000000", DivResultE); else n_pass++;
      RemSelE = 1'b1; #1;
      n_total++; if (DivResultE !== 32'd0) $display("FAIL ovf_rem got %h want 0", DivResultE); else n_pass++;
      RemSelE = 1'b0;
   endtask

   task automatic test_start_held;
      int vc, ns, nv, ls;
      do_op(32'd1000, 32'd3, 1'b0, vc, ns, nv, ls);
      n_total++; if (nv !== 1) $display("FAIL held_valid_pulses got %0d want 1", nv); else n_pass++;
      n_total++; if (DivBusyE !== 1'b0 || DivStallE !== 1'b0) $display("FAIL held_idle got busy=%b stall=%b want 0/0", DivBusyE, DivStallE); else n_pass++;
      n_total++; if (DivResultE !== 32'd333) $display("FAIL held_quo got %0d want 333", DivResultE); else n_pass++;
   endtask

   // use_rst = 0: abort at cycle 10; use_rst = 1: reset at cycle 10
   task automatic test_abort(input bit use_rst);
      int vc, ns, nv, ls;
      int nvalid;
      logic [31:0] want;
      RemSelE = 1'b0;
      do_op(32'd100, 32'd7, 1'b0, vc, ns, nv, ls);
      @(posedge CLK); #1;
      DivStartE = 1'b1; SrcAE = 32'd100; SrcBE = 32'd7; DivSignedE = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      if (use_rst) RST = 1'b1; else AbortE = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; AbortE = 1'b0; DivStartE = 1'b0;
      @(negedge CLK);
      n_total++; if (DivBusyE !== 1'b0 || DivStallE !== 1'b0)
         $display("FAIL abort_idle rst=%0d got busy=%b stall=%b want 0/0", use_rst, DivBusyE, DivStallE);
      else n_pass++;
      nvalid = 0;
      for (int c = 0; c < 40; c++) begin
         if (DivValidE) nvalid++;
         @(negedge CLK);
      end
      n_total++; if (nvalid !== 0) $display("FAIL abort_no_valid rst=%0d got %0d want 0", use_rst, nvalid); else n_pass++;
      want = use_rst ? 32'd0 : 32'd14;
      n_total++; if (DivResultE !== want) $display("FAIL abort_quo rst=%0d got %0d want %0d", use_rst, DivResultE, want); else n_pass++;
      RemSelE = 1'b1; #1;
      want = use_rst ? 32'd0 : 32'd2;
      n_total++; if (DivResultE !== want) $display("FAIL abort_rem rst=%0d got %0d want %0d", use_rst, DivResultE, want); else n_pass++;
      RemSelE = 1'b0;
   endtask

   task automatic test_random;
      int vc, ns, nv, ls, want_vc;
      logic [31:0] a, b, q, r;
      logic sgn;
      for (int i = 0; i < 16; i++) begin
         a   = $urandom;
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       b = $urandom_range(1, 15);
            1:       b = (i % 5 == 0) ? 32'd0 : -32'($urandom_range(1, 9));
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         ref_div(a, b, sgn, q, r);
         want_vc = (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
         do_op(a, b, sgn, vc, ns, nv, ls);
         n_total++; if (vc !== want_vc) $display("FAIL rand%0d_valid_cycle got %0d want %0d", i, vc, want_vc); else n_pass++;
         RemSelE = 1'b0; #1;
         n_total++; if (DivResultE !== q) $display("FAIL rand%0d_quo a=%h b=%h s=%b got %h want %h", i, a, b, sgn, DivResultE, q); else n_pass++;
         RemSelE = 1'b1; #1;
         n_total++; if (DivResultE !== r) $display("FAIL rand%0d_rem a=%h b=%h s=%b got %h want %h", i, a, b, sgn, DivResultE, r); else n_pass++;
         RemSelE = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed_cached();
      test_special();
      test_start_held();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller and iterative radix-2 datapath for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage. It accepts a start pulse from the decode/execute pipeline register, raises a stall request to the hazard unit for the duration of the operation, and holds the final quotient and remainder in result registers. A back-to-back DIV/REM pair on the same source registers therefore reads the held result without restarting.

## Interface
Parameters:
- XLEN, 32, operand/result width
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > XLEN

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- DivStartE  in  1  start request; held high by the E pipeline register while the stall holds the instruction
- DivSignedE  in  1  1 = DIV/REM (signed), 0 = DIVU/REMU
- RemSelE  in  1  result select: 1 = remainder, 0 = quotient
- SrcAE  in  XLEN  dividend (forwarded)
- SrcBE  in  XLEN  divisor (forwarded)
- AbortE  in  1  cancel an in-flight operation (trap/redirect)
- DivStallE  out  1  stall request to hazard unit (stall F/D/E, bubble M)
- DivValidE  out  1  one-cycle pulse: result registers were just updated
- DivBusyE  out  1  state == BUSY
- DivResultE  out  XLEN  RemSelE ? RemReg : QuoReg (combinational mux of registers)

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, QuoReg = 0, RemReg = 0, counter = 0, all outputs 0 except DivResultE = 0.
- IDLE, DivStartE = 0: no action. A DIV/REM issued without start reads the held registers.
- IDLE, DivStartE = 1:
  - Operands are latched.
  - If DivSignedE = 1, magnitudes are used, and the negate flags are latched: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Special cases go directly to DONE, writing registers on that edge:
    - divisor == 0: Quo = all ones, Rem = SrcAE.
    - signed, SrcAE == 0x80000000 and SrcBE == all ones: Quo = 0x80000000, Rem = 0.
  - Otherwise go to BUSY with counter = 0, partial remainder = 0, and the dividend magnitude in the shift register.
- BUSY:
  - Each cycle: shift {P, D} left by 1. If P[XLEN:0] minus divisor is non-negative (XLEN+1-bit subtract), replace P with the difference and set quotient bit 1.
  - The counter increments each cycle. When the counter reaches XLEN-1, go to DONE.
  - Sign correction is applied on that transition edge: the quotient is negated if its flag is set, the remainder if its flag is set.
  - QuoReg and RemReg are written only on the transition edge.
- DONE: DivValidE = 1 and DivStallE = 0, so the instruction advances. DONE always returns to IDLE. DivStartE, still high this cycle, must NOT restart the operation.
- AbortE = 1 in any state:
  - Next state is IDLE.
  - QuoReg and RemReg are unchanged.
  - No DivValidE pulse.
  - AbortE has priority over a DONE transition on the same edge.
- RST has priority over AbortE and DivStartE.

## Timing
- DivStallE = (IDLE & DivStartE & ~AbortE) | BUSY. It is combinational, so the start cycle is itself stalled.
- Normal op with start at cycle 0:
  - BUSY in cycles 1..XLEN.
  - DONE in cycle XLEN+1 (33). DivValidE and the valid DivResultE appear in cycle 33.
  - DivStallE is high in cycles 0..32.
- Special case with start at cycle 0: DONE in cycle 1, and DivStallE is high in cycle 0 only.
- Abort at cycle k: the state is IDLE at cycle k+1, and DivStallE is low from k+1.
- Cached read: no stall; DivResultE is valid in the same cycle.

## Test plan
- DIVU 100/7, start cycle 0 -> DivStallE high cycles 0..32; cycle 33: DivValidE = 1, quotient 14; with RemSelE = 1, result 2.
- DIV −7/2 -> Quo = 0xFFFFFFFD (−3), Rem = 0xFFFFFFFF (−1). Then with DivStartE = 0 and RemSelE toggled, DivResultE returns each value with no stall.
- DIV 5/0 -> DONE at cycle 1, Quo = 0xFFFFFFFF, Rem = 5, stall only in cycle 0. Then DIV 0x80000000/0xFFFFFFFF -> Quo = 0x80000000, Rem = 0.
- DivStartE held high through DONE -> exactly one DivValidE pulse, and the state returns to IDLE with no second operation.
- AbortE at cycle 10 of 100/7 after a prior result of 14 -> IDLE at cycle 11, no DivValidE pulse, QuoReg still 14. Repeat with RST at cycle 10 -> all registers 0.
